// File: rtl/lsu_mem_master_if.sv
// CPU request/response handshake plus data-memory byte-lane bus for lsu_mem_master.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        write_mem_4B;
  logic        write_mem_2B;
  logic        write_mem_1B;
  logic        read_mem_4B;
  logic        read_mem_2B;
  logic        read_mem_1B;
  logic        extension_mem;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] out_mem;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, out_mem,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output write_mem_4B, write_mem_2B, write_mem_1B,
    output read_mem_4B, read_mem_2B, read_mem_1B,
    output extension_mem, address, write_data
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, out_mem,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  write_mem_4B, write_mem_2B, write_mem_1B,
    input  read_mem_4B, read_mem_2B, read_mem_1B,
    input  extension_mem, address, write_data
  );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator: aligned accesses in one cycle, misaligned split into bytes.
// Define MISALIGN_TRAP_EN to fault misaligned accesses instead of splitting them.
module lsu_mem_master #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic             clk,
  input  logic             rst,
  lsu_mem_master_if.master bus
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAccess, StSplit, StResp} state_e;
`endif

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] result_q, result_d;
  logic        fault_q, fault_d;

  logic [2:0]  size_req;
  logic [32:0] last_byte;
  logic        misaligned;
  logic        req_fault;

  always_comb begin
    unique case (bus.req_funct3[1:0])
      2'b00:   size_req = 3'd1;
      2'b01:   size_req = 3'd2;
      default: size_req = 3'd4;
    endcase
    // 33-bit sum so an access near 0xFFFFFFFF cannot wrap into range
    last_byte  = {1'b0, bus.req_addr} + 33'(size_req) - 33'd1;
    misaligned = ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)) ||
                 ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]);
    req_fault  = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                 (bus.req_store && bus.req_funct3[2]) || (last_byte >= 33'(MEM_BYTES));
`ifdef MISALIGN_TRAP_EN
    req_fault  = req_fault || misaligned;
`else
  end

  logic [1:0]  k_q, k_d;
  logic [1:0]  last_k;
  logic [31:0] merged;

  always_comb begin
    last_k = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
    merged = result_q;
    merged[{k_q, 3'b000} +: 8] = bus.out_mem[7:0];
    if ((k_q == last_k) && (funct3_q[1:0] == 2'b01) && !funct3_q[2]) begin
      merged[31:16] = {16{merged[15]}};
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    fault_d  = fault_q;
`ifndef MISALIGN_TRAP_EN
    k_d      = k_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          store_d  = bus.req_store;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          result_d = '0;
          fault_d  = req_fault;
`ifdef MISALIGN_TRAP_EN
          state_d  = req_fault ? StResp : StAccess;
`else
          k_d      = 2'd0;
          state_d  = req_fault ? StResp : (misaligned ? StSplit : StAccess);
`endif
        end
      end
      StAccess: begin
        if (!store_q) result_d = bus.out_mem;
        state_d = StResp;
      end
`ifndef MISALIGN_TRAP_EN
      StSplit: begin
        if (!store_q) result_d = merged;
        if (k_q == last_k) begin
          k_d     = 2'd0;
          state_d = StResp;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      fault_q  <= 1'b0;
`ifndef MISALIGN_TRAP_EN
      k_q      <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      fault_q  <= fault_d;
`ifndef MISALIGN_TRAP_EN
      k_q      <= k_d;
`endif
    end
  end

  // Outputs are gated by rst so a reset mid-split commits no further bytes
  always_comb begin
    bus.req_ready     = (state_q == StIdle);
    bus.resp_valid    = 1'b0;
    bus.resp_rdata    = '0;
    bus.resp_fault    = 1'b0;
    bus.write_mem_4B  = 1'b0;
    bus.write_mem_2B  = 1'b0;
    bus.write_mem_1B  = 1'b0;
    bus.read_mem_4B   = 1'b0;
    bus.read_mem_2B   = 1'b0;
    bus.read_mem_1B   = 1'b0;
    bus.extension_mem = 1'b0;
    bus.address       = '0;
    bus.write_data    = '0;
    if (!rst) begin
      unique case (state_q)
        StAccess: begin
          bus.address    = addr_q;
          bus.write_data = wdata_q;
          if (store_q) begin
            bus.write_mem_1B = (funct3_q[1:0] == 2'b00);
            bus.write_mem_2B = (funct3_q[1:0] == 2'b01);
            bus.write_mem_4B = (funct3_q[1:0] == 2'b10);
          end else begin
            bus.read_mem_1B   = (funct3_q[1:0] == 2'b00);
            bus.read_mem_2B   = (funct3_q[1:0] == 2'b01);
            bus.read_mem_4B   = (funct3_q[1:0] == 2'b10);
            bus.extension_mem = ~funct3_q[2];
          end
        end
`ifndef MISALIGN_TRAP_EN
        StSplit: begin
          bus.address    = addr_q + {30'b0, k_q};
          bus.write_data = {24'b0, wdata_q[{k_q, 3'b000} +: 8]};
          bus.write_mem_1B = store_q;
          bus.read_mem_1B  = ~store_q;
        end
`endif
        StResp: begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = result_q;
          bus.resp_fault = fault_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a 64-byte byte-lane memory model.
module tb_lsu_mem_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_mem_master_if bus ();
  lsu_mem_master #(.MEM_BYTES(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem [0:63];
  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] rdb(input logic [31:0] a);
    if (a < 32'd64) return mem[a[5:0]];
    return 8'h00;
  endfunction

  always_comb begin
    logic [15:0] h;
    logic [7:0]  b;
    h = {rdb(bus.address + 32'd1), rdb(bus.address)};
    b = rdb(bus.address);
    bus.out_mem = '0;
    if (bus.read_mem_4B)
      bus.out_mem = {rdb(bus.address + 32'd3), rdb(bus.address + 32'd2), h};
    else if (bus.read_mem_2B)
      bus.out_mem = bus.extension_mem ? {{16{h[15]}}, h} : {16'b0, h};
    else if (bus.read_mem_1B)
      bus.out_mem = bus.extension_mem ? {{24{b[7]}}, b} : {24'b0, b};
  end

  always @(posedge clk) begin
    int n;
    logic [31:0] idx;
    n = bus.write_mem_4B ? 4 : bus.write_mem_2B ? 2 : bus.write_mem_1B ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      idx = bus.address + 32'(i);
      if (i < n && idx < 32'd64) mem[idx[5:0]] <= bus.write_data[8*i +: 8];
    end
  end

  logic [5:0]  stb;
  assign stb = {bus.write_mem_4B, bus.write_mem_2B, bus.write_mem_1B,
                bus.read_mem_4B, bus.read_mem_2B, bus.read_mem_1B};

  // Per-request observations filled in by do_req
  int          lat, nstb;
  logic        ext_seen, multi, flt;
  logic [31:0] rd;
  logic [31:0] log_addr [8];
  logic [31:0] log_data [8];
  logic [5:0]  log_stb  [8];

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = -1; nstb = 0; ext_seen = 1'b0; multi = 1'b0; rd = 'x; flt = 1'bx;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if ($countones(stb) > 1) multi = 1'b1;
      if (stb != 6'b0) begin
        if (nstb < 8) begin
          log_addr[nstb] = bus.address; log_data[nstb] = bus.write_data;
          log_stb[nstb] = stb;
        end
        nstb++;
      end
      ext_seen |= bus.extension_mem;
      if (bus.resp_valid) begin lat = c; rd = bus.resp_rdata; flt = bus.resp_fault; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", bus.resp_valid); end
    checks++; if (stb !== 6'b0) begin errors++; $display("FAIL rst_strobes got %b want 000000", stb); end
    checks++; if (bus.address !== 32'h0 || bus.write_data !== 32'h0) begin errors++; $display("FAIL rst_bus got addr %h data %h want 0", bus.address, bus.write_data); end
    checks++; if (bus.resp_rdata !== 32'h0 || bus.resp_fault !== 1'b0 || bus.extension_mem !== 1'b0) begin errors++; $display("FAIL rst_misc got rdata %h fault %b ext %b want 0", bus.resp_rdata, bus.resp_fault, bus.extension_mem); end
  endtask

  task automatic test_aligned_word();
    do_req(1'b1, 3'b010, 32'h10, 32'h11223344);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d want 2", lat); end
    checks++; if (nstb !== 1 || log_stb[0] !== 6'b100000) begin errors++; $display("FAIL sw_strobe got n=%0d stb=%b want 1 of 100000", nstb, log_stb[0]); end
    checks++; if (log_addr[0] !== 32'h10 || log_data[0] !== 32'h11223344) begin errors++; $display("FAIL sw_bus got %h/%h want 10/11223344", log_addr[0], log_data[0]); end
    checks++; if (rd !== 32'h0 || flt !== 1'b0) begin errors++; $display("FAIL sw_resp got %h/%b want 0/0", rd, flt); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'h11223344 || flt !== 1'b0) begin errors++; $display("FAIL lw_data got %h/%b want 11223344/0", rd, flt); end
  endtask

  task automatic test_byte_ext();
    do_req(1'b0, 3'b000, 32'h13, 32'h0);
    checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL lb_13 got %h want 00000011", rd); end
    do_req(1'b1, 3'b000, 32'h14, 32'h00000080);
    checks++; if (nstb !== 1 || log_stb[0] !== 6'b001000) begin errors++; $display("FAIL sb_strobe got n=%0d stb=%b want 1 of 001000", nstb, log_stb[0]); end
    do_req(1'b0, 3'b000, 32'h14, 32'h0);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sign got %h want ffffff80", rd); end
    checks++; if (ext_seen !== 1'b1) begin errors++; $display("FAIL lb_ext got %b want 1", ext_seen); end
    do_req(1'b0, 3'b100, 32'h14, 32'h0);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_zero got %h want 00000080", rd); end
    checks++; if (ext_seen !== 1'b0) begin errors++; $display("FAIL lbu_ext got %b want 0", ext_seen); end
  endtask

`ifndef MISALIGN_TRAP_EN
  task automatic test_split();
    logic [31:0] want_d [4];
    want_d[0] = 32'hDD; want_d[1] = 32'hCC; want_d[2] = 32'hBB; want_d[3] = 32'hAA;
    do_req(1'b1, 3'b010, 32'h21, 32'hAABBCCDD);
    checks++; if (lat !== 5 || nstb !== 4) begin errors++; $display("FAIL ssw_shape got lat %0d n %0d want 5/4", lat, nstb); end
    checks++; if (multi !== 1'b0) begin errors++; $display("FAIL ssw_onehot got multiple strobes want at most one"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_stb[i] !== 6'b001000 || log_addr[i] !== 32'h21 + 32'(i) || log_data[i] !== want_d[i]) begin
        errors++;
        $display("FAIL ssw_byte%0d got stb %b addr %h data %h want 001000 %h %h", i, log_stb[i], log_addr[i], log_data[i], 32'h21 + 32'(i), want_d[i]);
      end
    end
    do_req(1'b0, 3'b010, 32'h21, 32'h0);
    checks++; if (rd !== 32'hAABBCCDD || lat !== 5) begin errors++; $display("FAIL slw got %h lat %0d want aabbccdd lat 5", rd, lat); end
    checks++; if (ext_seen !== 1'b0) begin errors++; $display("FAIL slw_ext got %b want 0", ext_seen); end
    do_req(1'b0, 3'b001, 32'h23, 32'h0);
    checks++; if (rd !== 32'hFFFFAABB || lat !== 3) begin errors++; $display("FAIL slh got %h lat %0d want ffffaabb lat 3", rd, lat); end
    do_req(1'b0, 3'b101, 32'h23, 32'h0);
    checks++; if (rd !== 32'h0000AABB) begin errors++; $display("FAIL slhu got %h want 0000aabb", rd); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h21; bus.req_wdata = 32'h55667788;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (stb !== 6'b0 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_quiet got stb %b resp %b want 0/0", stb, bus.resp_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", bus.req_ready); end
    checks++; if (mem[6'h21] !== 8'h88) begin errors++; $display("FAIL midrst_b21 got %h want 88", mem[6'h21]); end
    checks++; if (mem[6'h22] !== 8'hCC || mem[6'h23] !== 8'hBB || mem[6'h24] !== 8'hAA) begin errors++; $display("FAIL midrst_kept got %h %h %h want cc bb aa", mem[6'h22], mem[6'h23], mem[6'h24]); end
  endtask
`else
  task automatic test_trap();
    do_req(1'b1, 3'b010, 32'h20, 32'h0BADF00D);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);
    checks++; if (rd !== 32'h0BADF00D || lat !== 2 || flt !== 1'b0) begin errors++; $display("FAIL trap_aligned got %h lat %0d f %b want 0badf00d 2 0", rd, lat, flt); end
    do_req(1'b0, 3'b010, 32'h21, 32'h0);
    checks++; if (flt !== 1'b1 || lat !== 1 || nstb !== 0 || rd !== 32'h0) begin errors++; $display("FAIL trap_lw21 got f %b lat %0d n %0d rd %h want 1 1 0 0", flt, lat, nstb, rd); end
  endtask
`endif

  task automatic test_fault();
    do_req(1'b0, 3'b011, 32'h0, 32'h0);
    checks++; if (flt !== 1'b1 || rd !== 32'h0 || lat !== 1 || nstb !== 0) begin errors++; $display("FAIL f3_011 got f %b rd %h lat %0d n %0d want 1 0 1 0", flt, rd, lat, nstb); end
    do_req(1'b1, 3'b100, 32'h0, 32'h0);
    checks++; if (flt !== 1'b1 || lat !== 1 || nstb !== 0) begin errors++; $display("FAIL sbu got f %b lat %0d n %0d want 1 1 0", flt, lat, nstb); end
    do_req(1'b0, 3'b010, 32'h3E, 32'h0);
    checks++; if (flt !== 1'b1 || rd !== 32'h0 || lat !== 1 || nstb !== 0) begin errors++; $display("FAIL lw_3e got f %b rd %h lat %0d n %0d want 1 0 1 0", flt, rd, lat, nstb); end
    do_req(1'b0, 3'b010, 32'h3C, 32'h0);
    checks++; if (flt !== 1'b0 || lat !== 2) begin errors++; $display("FAIL lw_3c got f %b lat %0d want 0 2", flt, lat); end
    do_req(1'b0, 3'b100, 32'h3F, 32'h0);
    checks++; if (flt !== 1'b0 || lat !== 2) begin errors++; $display("FAIL lbu_3f got f %b lat %0d want 0 2", flt, lat); end
    do_req(1'b0, 3'b000, 32'hFFFFFFFF, 32'h0);
    checks++; if (flt !== 1'b1 || lat !== 1) begin errors++; $display("FAIL lb_wrap got f %b lat %0d want 1 1", flt, lat); end
  endtask

  task automatic test_back_to_back();
    int c1, c2, rdy3;
    logic [31:0] d1, d2;
    c1 = -1; c2 = -1; rdy3 = -1; d1 = 'x; d2 = 'x;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    // Changed while busy; must only take effect at the second accept
    bus.req_funct3 = 3'b000; bus.req_addr = 32'h13;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) rdy3 = int'(bus.req_ready);
      if (bus.resp_valid) begin
        if (c1 < 0) begin c1 = c; d1 = bus.resp_rdata; end
        else begin c2 = c; d2 = bus.resp_rdata; end
      end
      if (c == 6) bus.req_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    checks++; if (c1 !== 2 || d1 !== 32'h11223344) begin errors++; $display("FAIL b2b_first got c %0d d %h want 2 11223344", c1, d1); end
    checks++; if (rdy3 !== 1) begin errors++; $display("FAIL b2b_ready got %0d want 1", rdy3); end
    checks++; if (c2 !== 5 || d2 !== 32'h00000011) begin errors++; $display("FAIL b2b_second got c %0d d %h want 5 00000011", c2, d2); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    test_reset();
    test_aligned_word();
    test_byte_ext();
`ifndef MISALIGN_TRAP_EN
    test_split();
    test_reset_mid();
`else
    test_trap();
`endif
    test_fault();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
Load/store initiator that drives the data-memory byte-lane interface (size strobes, extension flag, address, write data) from a CPU-side request handshake.
- Decodes RV32I funct3 for loads and stores.
- Performs aligned accesses in one memory cycle.
- Splits misaligned accesses into sequential byte accesses.
- Reassembles, sign- or zero-extends load data and returns it on a response pulse.
- Sits between the execute stage and data memory in the multi-cycle core.

Parameters:
MEM_BYTES, 64, size of the attached memory in bytes; any access touching a byte at or beyond this limit faults.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  block idle and able to accept
req_store  input  1  1 = store, 0 = load
req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, LSB-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_fault  output  1  qualifies resp_valid; illegal funct3 or out of range
write_mem_4B / write_mem_2B / write_mem_1B  output  1 each  memory write size strobes
read_mem_4B / read_mem_2B / read_mem_1B  output  1 each  memory read size strobes
extension_mem  output  1  1 = sign-extend memory read
address  output  32  memory byte address
write_data  output  32  memory write data
out_mem  input  32  memory combinational read data

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- FSM states: IDLE, ACCESS, SPLIT, RESP. Reset enters IDLE.
- req_ready = (state == IDLE). It is therefore 1 in the cycle after reset.
- Reset values: all other outputs are 0. Internal byte index k = 0.
- IDLE:
  - Accept on req_valid & req_ready; latch store flag, funct3, addr and wdata.
  - Size N = 1, 2 or 4 from funct3[1:0].
  - Fault if funct3 ∈ {011, 110, 111}, or store with funct3[2] = 1, or addr + N - 1 >= MEM_BYTES (check computed in 33 bits, no wrap). A fault goes straight to RESP with resp_fault = 1.
  - Otherwise aligned (W: addr[1:0] = 0; H: addr[0] = 0; B: always) → ACCESS. Misaligned → SPLIT with k = 0.
- ACCESS (exactly 1 cycle):
  - Exactly one strobe for size N is high; address = addr; write_data = wdata.
  - extension_mem = ~funct3[2] for loads, 0 for stores.
  - Loads capture out_mem into the result at the clock edge ending the cycle. Stores commit at that same edge.
  - Next state: RESP.
- SPLIT (N cycles, k = 0 … N-1):
  - write_mem_1B or read_mem_1B is high; address = addr + k; extension_mem = 0.
  - write_data[7:0] = wdata[8k+7:8k]; upper bits 0.
  - Loads place out_mem[7:0] into result[8k+7:8k].
  - After k = N-1, loads are extended from bit 8N-1 per funct3[2] (0 = sign, 1 = zero). Next state: RESP.
- RESP (1 cycle):
  - resp_valid = 1; resp_rdata = result (0 for stores and faults); resp_fault as latched.
  - All memory strobes are 0. Next state: IDLE.
- Outside ACCESS/SPLIT: every strobe, extension_mem, address and write_data is 0. At most one strobe is high in any cycle.
- Latency from the accept edge to resp_valid: aligned 2 cycles, misaligned N+1 cycles, fault 1 cycle.
- Back-to-back requests: the next request is accepted in the cycle after RESP.
- Request inputs are ignored while not in IDLE.
- Reset mid-operation: the next cycle has no strobes, no resp_valid and req_ready = 1. Bytes already written remain in memory.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a misaligned access is a fault, handled like any fault (1 cycle, no strobes, resp_fault = 1). The SPLIT state is not compiled.
- Undefined: misaligned accesses are split as described in Behaviour.

Test Plan:
- SW 0x11223344 @0x10, then LW @0x10 → single write_mem_4B cycle; read returns 0x11223344; resp_valid 2 cycles after each accept.
- LB @0x13 → 0x00000011. After SB 0x80 @0x14: LB @0x14 → 0xFFFFFF80 with extension_mem = 1 in ACCESS; LBU @0x14 → 0x00000080 with extension_mem = 0.
- SW 0xAABBCCDD @0x21 → four write_mem_1B cycles at 0x21..0x24 with data DD, CC, BB, AA. LW @0x21 → 0xAABBCCDD at 5 cycles. LH @0x23 → 0xFFFFAABB. LHU @0x23 → 0x0000AABB.
- funct3 = 011 load, SB with funct3 = 100, and LW @0x3E (MEM_BYTES = 64) → resp_fault = 1, resp_rdata = 0, no strobes, resp_valid 1 cycle after accept.
- rst asserted during k = 1 of the split SW @0x21 → zero strobes and no resp_valid the next cycle; req_ready = 1; bytes 0x22..0x24 unchanged.
- With MISALIGN_TRAP_EN defined: LW @0x21 → fault in 1 cycle, no strobes. Aligned LW @0x20 is unaffected.
